// File: rtl/led_chaser_ctrl.sv
// LED chaser: programmable-period step counter driving rotate,
// bounce and blink patterns, with optional active-low LED drive.
module led_chaser_ctrl #(
  parameter int LED_NUM    = 4,
  parameter int CNT_W      = 25,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [CNT_W-1:0]   tick_max,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step
);

  typedef enum logic [1:0] {
    M_ROL = 2'd0,
    M_ROR = 2'd1,
    M_BNC = 2'd2,
    M_BLK = 2'd3
  } mode_e;

  localparam logic [LED_NUM-1:0] ONE = LED_NUM'(1);
  localparam logic [CNT_W-1:0]   INC = CNT_W'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_e              mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [LED_NUM-1:0] pat_q, pat_d;
  logic               step_q, step_d;

  mode_e              mode_in;
  logic [LED_NUM-1:0] pat_nxt;
  logic               dir_nxt;

  assign mode_in = mode_e'(mode);

  // dir_q = 1 means the lit bit travels toward the MSB
  always_comb begin
    pat_nxt = pat_q;
    dir_nxt = dir_q;
    unique case (mode_q)
      M_ROL: pat_nxt = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
      M_ROR: pat_nxt = {pat_q[0], pat_q[LED_NUM-1:1]};
      M_BNC: begin
        if (dir_q) begin
          pat_nxt = pat_q << 1;
          if (pat_nxt[LED_NUM-1]) dir_nxt = 1'b0;
        end else begin
          pat_nxt = pat_q >> 1;
          if (pat_nxt[0]) dir_nxt = 1'b1;
        end
      end
      M_BLK: pat_nxt = ~pat_q;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    step_d = 1'b0;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      cnt_d  = '0;
      dir_d  = 1'b1;
      pat_d  = (mode_in == M_BLK) ? '0 : ONE;
    end else if (en) begin
      if (cnt_q == tick_max) begin
        cnt_d  = '0;
        step_d = 1'b1;
        pat_d  = pat_nxt;
        dir_d  = dir_nxt;
      end else if (cnt_q > tick_max) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      mode_q <= M_ROL;
      dir_q  <= 1'b1;
      pat_q  <= ONE;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      step_q <= step_d;
    end
  end

  assign led  = ACTIVE_LOW ? ~pat_q : pat_q;
  assign step = step_q;

endmodule
